pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the core (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing the fixed-field, always-advancing stage registers.
- Adds a valid/ready handshake, back-pressure (stall), synchronous flush, and bubble insertion with zeroed control.
- Optional skid buffer gives a fully registered ready path. A saturating stall-cycle counter supports performance debug.

Parameters:
- DATA_W, 32: width of the payload bus (pc, operands, immediates, register indices concatenated by the instantiating stage).
- CTRL_W, 16: width of the control bundle. Forced to zero whenever the stage holds a bubble.
- SKID, 0: 0 = single register with combinational ready; 1 = main plus skid register with registered ready_o.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_i  input  1  upstream holds a valid instruction.
- ready_o  output  1  stage can accept; transfer when valid_i && ready_o.
- data_i  input  DATA_W  upstream payload.
- ctrl_i  input  CTRL_W  upstream control bundle.
- valid_o  output  1  stage output holds a valid instruction.
- ready_i  input  1  downstream accepts; transfer when valid_o && ready_i.
- data_o  output  DATA_W  registered payload.
- ctrl_o  output  CTRL_W  registered control; 0 when valid_o=0.
- flush_i  input  1  synchronous kill of all held and incoming instructions.
- stall_cnt_o  output  CNT_W  saturating count of cycles with valid_o && !ready_i.
- stall_clr_i  input  1  synchronous clear of stall_cnt_o.

Behaviour:
- Reset (asynchronous, any time, including mid-stall):
  - valid_o=0, data_o=0, ctrl_o=0, stall_cnt_o=0, skid entry empty.
  - ready_o=1 once rst_n=1 (SKID=1: ready_o=1 during reset as well).
- Latency: 1 cycle from accepted input to valid_o. Throughput is 1 transfer/cycle when ready_i=1.
- All outputs (valid_o, data_o, ctrl_o, stall_cnt_o) come directly from flops. ready_o is combinational only when SKID=0.
- SKID=0:
  - ready_o = !valid_o || ready_i.
  - On an input transfer, the main register loads data_i/ctrl_i and sets valid_o=1.
  - On an output transfer with no input transfer, valid_o=0 and ctrl_o=0.
  - When valid_o && !ready_i, the main register holds its value (stall).
- SKID=1:
  - ready_o = !skid_valid (registered).
  - An input accepted while the main register is occupied and ready_i=0 goes to the skid register.
  - When the downstream drains the main register, the skid contents move to the main register in the same edge; otherwise the new input is loaded.
  - Ordering is strictly FIFO. At most 2 instructions are held. No input is ever dropped except by flush.
- Bubble rule: ctrl_o==0 whenever valid_o==0, checked every cycle. data_o retains its last value when a bubble forms.
- Flush:
  - flush_i=1 at an edge forces valid_o=0, ctrl_o=0 and empties the skid entry.
  - An input presented in the same cycle is discarded, even if ready_o=1.
  - Flush overrides both input and output transfers.
  - ready_o=1 in the cycle after the flush.
- Stall counter:
  - Increments by 1 each cycle with valid_o && !ready_i && !flush_i.
  - Saturates at all-ones and holds there.
  - stall_clr_i sets it to 0. Clear has priority over increment.
- Invariant: if valid_o=1 and ready_i=0, then data_o, ctrl_o and valid_o are stable into the next cycle unless flush_i or rst_n asserts. The bench asserts this.

Test Plan:
- Streaming, ready_i=1: valid_i=1 with data_i=0x00000010,0x14,0x18 on consecutive cycles -> the same sequence appears on data_o with valid_o=1, 1 cycle later. stall_cnt_o stays 0.
- Stall, SKID=0: with valid_o=1, data_o=0x20, ctrl_o=0x00A5, hold ready_i=0 for 3 cycles -> outputs stay stable, ready_o=0, stall_cnt_o=3. Release -> the next input appears the following cycle.
- Skid, SKID=1: valid_i=1 with 0xA,0xB and ready_i dropped when 0xA reaches the output -> 0xB is captured in skid and ready_o=0 next cycle. Raise ready_i -> data_o sequence is 0xA, 0xB, 0xC, with no loss or duplication.
- Flush with SKID=1, both entries full, plus valid_i=1 in the same cycle: assert flush_i for 1 cycle -> valid_o=0, ctrl_o=0 next cycle, ready_o=1, and none of the three instructions ever appears at the output.
- Saturation with CNT_W=4: hold a stall for 20 cycles -> stall_cnt_o reaches 15 and holds. Assert stall_clr_i while still stalled -> 0 next cycle, then counts from 1.
- Reset mid-operation: drop rst_n asynchronously between edges while stalled with skid full -> valid_o=0, ctrl_o=0, data_o=0, stall_cnt_o=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush,
// zeroed-control bubbles, optional skid entry and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  input  logic              stall_clr_i
);

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic [CTRL_W-1:0] ctrl_p0;
  logic [CNT_W-1:0]  stall_cnt;
  logic              in_xfer;
  logic              out_xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = vld_p0 && ready_i;

  generate
    if (SKID == 0) begin : g_noskid
      assign ready_o = !vld_p0 || ready_i;

      // Stage p0: single main register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p0  <= 1'b0;
          data_p0 <= '0;
          ctrl_p0 <= '0;
        end else if (flush_i) begin
          vld_p0  <= 1'b0;
          ctrl_p0 <= '0;
        end else if (in_xfer) begin
          vld_p0  <= 1'b1;
          data_p0 <= data_i;
          ctrl_p0 <= ctrl_i;
        end else if (out_xfer) begin
          vld_p0  <= 1'b0;
          ctrl_p0 <= '0;
        end
      end
    end else begin : g_skid
      logic              skid_vld;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;

      // ready_o depends only on the skid flop, so it is registered
      assign ready_o = !skid_vld;

      // Stage p0: main register backed by one skid entry (FIFO order)
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p0    <= 1'b0;
          data_p0   <= '0;
          ctrl_p0   <= '0;
          skid_vld  <= 1'b0;
          skid_data <= '0;
          skid_ctrl <= '0;
        end else if (flush_i) begin
          vld_p0    <= 1'b0;
          ctrl_p0   <= '0;
          skid_vld  <= 1'b0;
          skid_ctrl <= '0;
        end else if (!vld_p0 || out_xfer) begin
          if (skid_vld) begin
            vld_p0    <= 1'b1;
            data_p0   <= skid_data;
            ctrl_p0   <= skid_ctrl;
            skid_vld  <= 1'b0;
            skid_ctrl <= '0;
          end else if (in_xfer) begin
            vld_p0  <= 1'b1;
            data_p0 <= data_i;
            ctrl_p0 <= ctrl_i;
          end else begin
            vld_p0  <= 1'b0;
            ctrl_p0 <= '0;
          end
        end else if (in_xfer) begin
          skid_vld  <= 1'b1;
          skid_data <= data_i;
          skid_ctrl <= ctrl_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr_i) begin
      stall_cnt <= '0;
    end else if (vld_p0 && !ready_i && !flush_i) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign valid_o     = vld_p0;
  assign data_o      = data_p0;
  assign ctrl_o      = ctrl_p0;
  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=0 instance (a) and a SKID=1,
// CNT_W=4 instance (b), plus per-cycle bubble and stall-stability checks.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  int          errors = 0;
  int          checks = 0;

  logic        va, ra_o, vao, rdya, fla, clra;
  logic [31:0] da, dao;
  logic [15:0] ca, cao;
  logic [15:0] sca;

  logic        vb, rb_o, vbo, rdyb, flb, clrb;
  logic [31:0] db, dbo;
  logic [15:0] cb, cbo;
  logic [3:0]  scb;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_i(va), .ready_o(ra_o), .data_i(da),
    .ctrl_i(ca), .valid_o(vao), .ready_i(rdya), .data_o(dao), .ctrl_o(cao),
    .flush_i(fla), .stall_cnt_o(sca), .stall_clr_i(clra));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_i(vb), .ready_o(rb_o), .data_i(db),
    .ctrl_i(cb), .valid_o(vbo), .ready_i(rdyb), .data_o(dbo), .ctrl_o(cbo),
    .flush_i(flb), .stall_cnt_o(scb), .stall_clr_i(clrb));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle bubble rule and stall stability for both instances
  logic        pa_st, pb_st;
  logic [31:0] pa_d, pb_d;
  logic [15:0] pa_c, pb_c;
  always begin
    @(posedge clk);
    pa_st = rst_n && vao && !rdya && !fla;
    pb_st = rst_n && vbo && !rdyb && !flb;
    pa_d = dao; pa_c = cao; pb_d = dbo; pb_c = cbo;
    #1;
    if (rst_n) begin
      if (!vao) chk("bubble_a", {48'd0, cao}, 64'd0);
      if (!vbo) chk("bubble_b", {48'd0, cbo}, 64'd0);
      if (pa_st) chk("hold_a", {vao, cao, dao}, {1'b1, pa_c, pa_d});
      if (pb_st) chk("hold_b", {vbo, cbo, dbo}, {1'b1, pb_c, pb_d});
    end
  end

  initial begin
    rst_n = 1'b0;
    va = 0; da = '0; ca = '0; rdya = 1; fla = 0; clra = 0;
    vb = 0; db = '0; cb = '0; rdyb = 1; flb = 0; clrb = 0;
    #12;
    chk("rst_a", {vao, cao, dao, sca}, 64'd0);
    chk("rst_b", {vbo, cbo, dbo, 12'd0, scb}, 64'd0);
    chk("rst_rdy_b", rb_o, 1);
    rst_n = 1'b1;
    #1;
    chk("rdy_a_after_rst", ra_o, 1);

    // Streaming through instance a
    va = 1; da = 32'h10; ca = 16'h1;
    tick(); chk("strm0", {vao, dao}, {1'b1, 32'h10});
    da = 32'h14; ca = 16'h2;
    tick(); chk("strm1", {vao, dao}, {1'b1, 32'h14});
    da = 32'h18; ca = 16'h3;
    tick(); chk("strm2", {vao, dao, cao}, {1'b1, 32'h18, 16'h3});
    va = 0;
    tick(); chk("strm_bubble", {vao, cao, dao}, {1'b0, 16'h0, 32'h18});
    chk("strm_cnt", sca, 0);

    // Stall on instance a
    va = 1; da = 32'h20; ca = 16'h00A5;
    tick(); chk("stall_load", {vao, cao, dao}, {1'b1, 16'h00A5, 32'h20});
    rdya = 0; da = 32'h24; ca = 16'h00A6;
    #1; chk("stall_rdy", ra_o, 0);
    tick(); tick(); tick();
    chk("stall_hold", {vao, cao, dao}, {1'b1, 16'h00A5, 32'h20});
    chk("stall_cnt3", sca, 3);
    chk("stall_rdy3", ra_o, 0);
    rdya = 1;
    #1; chk("release_rdy", ra_o, 1);
    tick(); chk("release_next", {vao, cao, dao}, {1'b1, 16'h00A6, 32'h24});
    chk("release_cnt", sca, 3);
    va = 0;
    tick(); chk("drain_a", vao, 0);
    clra = 1;
    tick(); chk("clr_a", sca, 0);
    clra = 0;

    // Flush on instance a discards the same-cycle input
    va = 1; da = 32'h30; ca = 16'h7;
    tick(); chk("fl_a_load", dao, 32'h30);
    da = 32'h34; ca = 16'h8; fla = 1;
    tick(); chk("fl_a_out", {vao, cao, ra_o}, {1'b0, 16'h0, 1'b1});
    fla = 0; va = 0;
    tick(); chk("fl_a_gone", vao, 0);

    // Skid on instance b: A, B, C in order
    vb = 1; db = 32'hA; cb = 16'h11;
    tick(); chk("skid_a", {vbo, dbo}, {1'b1, 32'hA});
    rdyb = 0; db = 32'hB; cb = 16'h12;
    tick(); chk("skid_hold_a", {dbo, rb_o}, {32'hA, 1'b0});
    db = 32'hC; cb = 16'h13;
    tick(); chk("skid_cnt2", scb, 2);
    rdyb = 1;
    tick(); chk("skid_b", {vbo, cbo, dbo, rb_o}, {1'b1, 16'h12, 32'hB, 1'b1});
    tick(); chk("skid_c", {vbo, cbo, dbo}, {1'b1, 16'h13, 32'hC});
    vb = 0;
    tick(); chk("skid_empty", {vbo, cbo}, {1'b0, 16'h0});

    // Flush on instance b with both entries and an incoming input
    vb = 1; db = 32'h40; cb = 16'h21;
    tick(); chk("flb_main", dbo, 32'h40);
    rdyb = 0; db = 32'h41; cb = 16'h22;
    tick(); chk("flb_full", rb_o, 0);
    db = 32'h42; cb = 16'h23; flb = 1;
    tick(); chk("flb_out", {vbo, cbo, rb_o}, {1'b0, 16'h0, 1'b1});
    chk("flb_cnt", scb, 3);
    flb = 0; vb = 0; rdyb = 1;
    tick(); chk("flb_gone1", vbo, 0);
    tick(); chk("flb_gone2", vbo, 0);

    // Saturation of the 4-bit counter
    clrb = 1;
    tick(); chk("sat_clr0", scb, 0);
    clrb = 0; vb = 1; db = 32'h50; cb = 16'h31;
    tick(); chk("sat_load", dbo, 32'h50);
    rdyb = 0; vb = 0;
    repeat (20) tick();
    chk("sat_15", scb, 15);
    chk("sat_data", {vbo, dbo}, {1'b1, 32'h50});
    clrb = 1;
    tick(); chk("sat_clr", scb, 0);
    clrb = 0;
    tick(); chk("sat_cnt1", scb, 1);
    tick(); chk("sat_cnt2", scb, 2);

    // Asynchronous reset while stalled with skid full
    vb = 1; db = 32'h51; cb = 16'h32;
    tick(); chk("rst_mid_full", rb_o, 0);
    vb = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_b", {vbo, cbo, dbo, 12'd0, scb}, 64'd0);
    chk("rst_mid_rdy", rb_o, 1);
    chk("rst_mid_a", {vao, cao, dao, sca}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; rdyb = 1;
    tick(); chk("post_rst_b", vbo, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
